// File: rtl/frame_bit_counter.sv
// Bit-slot counter for the SERDES datapath: counts strobes through a frame of
// programmable length, pulses tick on frame completion and keeps a frame tally.
module frame_bit_counter #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_LEN = 10
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             tick,
    output logic [7:0]       frames
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [CNT_W-1:0] DefLen = CNT_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] remaining_q;
    logic             busy_q;
    logic             tick_q;
    logic [7:0]       frames_q;
    logic [CNT_W-1:0] len_d;

    // A zero length request falls back to the default frame length.
    assign len_d = (len == '0) ? DefLen : len;

    // Abort outranks the final strobe, which outranks start; start is only seen in IDLE.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            len_q       <= DefLen;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            frames_q    <= 8'd0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        len_q       <= len_d;
                        remaining_q <= len_d - One;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (en) begin
                        if (remaining_q == '0) begin
                            tick_q   <= 1'b1;
                            frames_q <= frames_q + 8'd1;
                            if (auto_reload) begin
                                remaining_q <= len_q - One;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            remaining_q <= remaining_q - One;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign tick      = tick_q;
    assign frames    = frames_q;

endmodule
